// File: rtl/dram_cache_pkg.sv
// Shared definitions for the core-side DRAM cache: FSM states, op encoding
// and the default bus widths used by the core and the DDR2 controller top.
package dram_cache_pkg;

  localparam int unsigned DRAM_ADDR_W = 27;
  localparam int unsigned DRAM_DATA_W = 32;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MEM_REQ,
    RESP
  } state_t;

endpackage

// File: rtl/dram_cache_ram.sv
// Single-port tag+data store: synchronous read, synchronous write, no reset,
// so it maps onto block RAM.
module dram_cache_ram #(
  parameter int unsigned WIDTH   = 49,
  parameter int unsigned DEPTH_W = 10
) (
  input  logic               clk,
  input  logic               we,
  input  logic [DEPTH_W-1:0] addr,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0] mem [1 << DEPTH_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dram_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with single-word lines
// sitting between the core DRAM port and the DDR2 controller.
module dram_cache
  import dram_cache_pkg::*;
#(
  parameter int unsigned ADDR_W  = DRAM_ADDR_W,
  parameter int unsigned DATA_W  = DRAM_DATA_W,
  parameter int unsigned INDEX_W = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] addr_dram,
  input  logic [DATA_W-1:0] din_dram,
  input  logic              rw_dram,
  input  logic              valid_dram,
  output logic              ready_dram,
  output logic [DATA_W-1:0] dout_dram,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_rw,
  output logic              mem_valid,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int unsigned TAG_W  = ADDR_W - INDEX_W;
  localparam int unsigned LINES  = 1 << INDEX_W;
  localparam int unsigned LINE_W = TAG_W + DATA_W;

  state_t              state;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_din;
  logic                req_rw;
  logic [LINES-1:0]    line_valid;

  logic [INDEX_W-1:0]  req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  ram_idx;
  logic                ram_we;
  logic [LINE_W-1:0]   ram_wdata;
  logic [LINE_W-1:0]   ram_rdata;
  logic [TAG_W-1:0]    rd_tag;
  logic [DATA_W-1:0]   rd_data;
  logic                hit;

  assign req_idx         = req_addr[INDEX_W-1:0];
  assign req_tag         = req_addr[ADDR_W-1:INDEX_W];
  assign {rd_tag, rd_data} = ram_rdata;

  // The lookup read is launched from the incoming address while idle so the
  // stored line is available in LOOKUP; every later access uses the latched index.
  always_comb begin
    hit       = line_valid[req_idx] && (rd_tag == req_tag);
    ram_idx   = (state == IDLE) ? addr_dram[INDEX_W-1:0] : req_idx;
    ram_we    = 1'b0;
    ram_wdata = {req_tag, req_din};
    if (state == LOOKUP && req_rw == RW_WRITE && hit) begin
      ram_we = 1'b1;
    end else if (state == MEM_REQ && mem_ready && req_rw == RW_READ) begin
      ram_we    = 1'b1;
      ram_wdata = {req_tag, mem_dout};
    end
  end

  dram_cache_ram #(
    .WIDTH   (LINE_W),
    .DEPTH_W (INDEX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      req_addr   <= '0;
      req_din    <= '0;
      req_rw     <= RW_READ;
      line_valid <= '0;
      ready_dram <= 1'b0;
      dout_dram  <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_rw     <= RW_READ;
      mem_valid  <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready_dram <= 1'b0;
          if (valid_dram) begin
            req_addr <= addr_dram;
            req_din  <= din_dram;
            req_rw   <= rw_dram;
            state    <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (req_rw == RW_READ && hit) begin
            dout_dram  <= rd_data;
            ready_dram <= 1'b1;
            if (hit_count != '1) begin
              hit_count <= hit_count + 32'd1;
            end
            state <= RESP;
          end else begin
            // Misses and all writes go to the controller; write hits were
            // already folded into the RAM by the combinational write enable.
            if (req_rw == RW_READ && miss_count != '1) begin
              miss_count <= miss_count + 32'd1;
            end
            mem_valid <= 1'b1;
            mem_rw    <= req_rw;
            mem_addr  <= req_addr;
            if (req_rw == RW_WRITE) begin
              mem_din <= req_din;
            end
            state <= MEM_REQ;
          end
        end

        MEM_REQ: begin
          if (mem_ready) begin
            mem_valid  <= 1'b0;
            ready_dram <= 1'b1;
            if (req_rw == RW_READ) begin
              dout_dram           <= mem_dout;
              line_valid[req_idx] <= 1'b1;
            end
            state <= RESP;
          end
        end

        RESP: begin
          ready_dram <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          ready_dram <= 1'b0;
          mem_valid  <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_cache.sv
// Directed plus randomized transactions against a line-array/backing-store
// model of the cache, with the controller emulated inline.
module tb_dram_cache;

  logic        clk = 1'b0;
  logic        rstn;
  logic [26:0] addr_dram;
  logic [31:0] din_dram;
  logic        rw_dram;
  logic        valid_dram;
  logic        ready_dram;
  logic [31:0] dout_dram;
  logic [26:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_rw;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_dout;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  always #5 clk = ~clk;

  dram_cache #(
    .ADDR_W  (27),
    .DATA_W  (32),
    .INDEX_W (10)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .addr_dram  (addr_dram),
    .din_dram   (din_dram),
    .rw_dram    (rw_dram),
    .valid_dram (valid_dram),
    .ready_dram (ready_dram),
    .dout_dram  (dout_dram),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_rw     (mem_rw),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_dout   (mem_dout),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int unsigned checks = 0;
  int unsigned fails  = 0;

  // Reference model: cache lines, backing memory, expected counters.
  bit          mv [1024];
  bit [16:0]   mt [1024];
  bit [31:0]   md [1024];
  bit [31:0]   bmem [bit [26:0]];
  bit [31:0]   exp_hits;
  bit [31:0]   exp_misses;
  bit [31:0]   last_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] backing(input bit [26:0] a);
    if (bmem.exists(a)) return bmem[a];
    return {a[4:0], a} ^ 32'h5A5A_1234;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) mv[i] = 1'b0;
    exp_hits   = '0;
    exp_misses = '0;
    last_dout  = '0;
  endtask

  // Caller is at a negedge with the cache idle. lat = cycles from mem_valid
  // first visible to the cycle mem_ready is driven high.
  task automatic txn(input logic [26:0] a, input logic [31:0] d, input logic rw, input int lat);
    int unsigned idx;
    bit [16:0]   t;
    bit          mhit;
    bit          memop;
    bit [31:0]   rdv;
    int          kexp;
    idx   = int'(a[9:0]);
    t     = a[26:10];
    mhit  = mv[idx] && (mt[idx] == t);
    memop = rw || !mhit;
    rdv   = '0;
    if (!rw) begin
      if (mhit) begin
        rdv = md[idx];
        if (exp_hits != 32'hFFFF_FFFF) exp_hits = exp_hits + 1;
      end else begin
        rdv = backing(a);
        if (exp_misses != 32'hFFFF_FFFF) exp_misses = exp_misses + 1;
        mv[idx] = 1'b1;
        mt[idx] = t;
        md[idx] = rdv;
      end
      last_dout = rdv;
    end else begin
      bmem[a] = d;
      if (mhit) md[idx] = d;
    end
    kexp = memop ? 3 + lat : 2;

    addr_dram  = a;
    din_dram   = d;
    rw_dram    = rw;
    valid_dram = 1'b1;
    for (int k = 1; k <= kexp; k++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (k < kexp) begin
        check("ready_early", ready_dram, 0);
        if (memop && k >= 2) begin
          check("mem_valid_held", mem_valid, 1);
          check("mem_addr", mem_addr, a);
          check("mem_rw", mem_rw, rw);
          if (rw) check("mem_din", mem_din, d);
          if (k == 2 + lat) begin
            mem_ready = 1'b1;
            mem_dout  = rw ? $urandom : rdv;
          end
        end else begin
          check("mem_valid_idle", mem_valid, 0);
        end
      end else begin
        check("ready_pulse", ready_dram, 1);
        check("mem_valid_drop", mem_valid, 0);
        if (!rw) check("dout", dout_dram, rdv);
      end
    end
    @(negedge clk);
    mem_ready  = 1'b0;
    valid_dram = 1'b0;
    check("ready_single", ready_dram, 0);
    check("dout_hold", dout_dram, last_dout);
    check("hit_count", hit_count, exp_hits);
    check("miss_count", miss_count, exp_misses);
  endtask

  initial begin
    rstn       = 1'b0;
    addr_dram  = '0;
    din_dram   = '0;
    rw_dram    = 1'b0;
    valid_dram = 1'b0;
    mem_ready  = 1'b0;
    mem_dout   = '0;
    model_reset();

    repeat (3) @(negedge clk);
    check("rst_ready", ready_dram, 0);
    check("rst_dout", dout_dram, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_mem_rw", mem_rw, 0);
    check("rst_hits", hit_count, 0);
    check("rst_misses", miss_count, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Cold miss, hit, write-through on hit, no-allocate write miss.
    bmem[27'h0000123] = 32'hDEAD_BEEF;
    txn(27'h0000123, 32'h0, 1'b0, 5);
    txn(27'h0000123, 32'h0, 1'b0, 0);
    txn(27'h0000123, 32'hCAFE_F00D, 1'b1, 2);
    txn(27'h0000123, 32'h0, 1'b0, 0);
    txn(27'h0000456, 32'h1111_2222, 1'b1, 1);
    txn(27'h0000456, 32'h0, 1'b0, 3);

    // Conflicts on index 0x123: read replaces, write leaves the line alone.
    txn(27'h0000523, 32'h0, 1'b0, 2);
    txn(27'h0000123, 32'h0, 1'b0, 1);
    txn(27'h0000923, 32'h0000_ABCD, 1'b1, 0);
    txn(27'h0000123, 32'h0, 1'b0, 0);

    // Slow controller.
    txn(27'h0000789, 32'h1357_2468, 1'b1, 100);
    txn(27'h0000789, 32'h0, 1'b0, 100);

    // Reset while waiting on the controller.
    addr_dram  = 27'h0000777;
    din_dram   = '0;
    rw_dram    = 1'b0;
    valid_dram = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_pending", mem_valid, 1);
    rstn = 1'b0;
    #1;
    check("midrst_mem_valid", mem_valid, 0);
    check("midrst_ready", ready_dram, 0);
    check("midrst_hits", hit_count, 0);
    check("midrst_misses", miss_count, 0);
    valid_dram = 1'b0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("postrst_ready", ready_dram, 0);
    end
    txn(27'h0000123, 32'h0, 1'b0, 2);

    // Randomized traffic over a few indices and tags to force hits and conflicts.
    for (int n = 0; n < 300; n++) begin
      logic [26:0] a;
      logic [31:0] d;
      logic        rw;
      int          lat;
      a   = {17'($urandom_range(0, 3)), 10'(10'h120 + $urandom_range(0, 7))};
      d   = $urandom;
      rw  = ($urandom_range(0, 2) == 0);
      lat = int'($urandom_range(0, 6));
      if ($urandom_range(0, 4) == 0) begin
        mem_ready = 1'b1;
        mem_dout  = $urandom;
        @(negedge clk);
        mem_ready = 1'b0;
        check("stray_ready", ready_dram, 0);
        check("stray_mem_valid", mem_valid, 0);
      end
      txn(a, d, rw, lat);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/dram_cache.md
Name: dram_cache

Overview:
- Direct-mapped, write-through, no-write-allocate cache between the core's DRAM request port and the DDR2 memory controller top.
- Consumes core requests (addr/din/rw/valid → ready/dout) and issues the same protocol downstream only on read misses and on all writes.
- Single-word lines; runs entirely in the core clock domain (clk).

Parameters:
- ADDR_W, 27, word address width; matches the core DRAM address bus.
- DATA_W, 32, data word width.
- INDEX_W, 10, index bits; 2**INDEX_W lines; tag width = ADDR_W-INDEX_W.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- addr_dram  in  ADDR_W  core request word address.
- din_dram  in  DATA_W  core write data.
- rw_dram  in  1  1=write, 0=read.
- valid_dram  in  1  core request valid; held with addr/din/rw stable until ready_dram.
- ready_dram  out  1  one-cycle completion pulse.
- dout_dram  out  DATA_W  read data, valid while ready_dram=1 for reads.
- mem_addr  out  ADDR_W  controller request address.
- mem_din  out  DATA_W  controller write data.
- mem_rw  out  1  controller op, same encoding.
- mem_valid  out  1  controller request valid.
- mem_ready  in  1  controller one-cycle completion pulse.
- mem_dout  in  DATA_W  controller read data, valid with mem_ready.
- hit_count  out  32  saturating read-hit counter.
- miss_count  out  32  saturating read-miss counter.

Behaviour:
- Reset (async, rstn=0): state IDLE; all line valid bits 0; ready_dram=0, dout_dram=0, mem_valid=0, mem_addr=0, mem_din=0, mem_rw=0, counters 0. Data/tag arrays are not reset.
- Line format: valid bit (flop array), tag (ADDR_W-INDEX_W), data (DATA_W); index = addr[INDEX_W-1:0], tag = addr[ADDR_W-1:INDEX_W].
- States: IDLE, LOOKUP, MEM_REQ, RESP.
- IDLE: when valid_dram=1, latch addr/din/rw, issue synchronous array read at index, go to LOOKUP. Otherwise stay.
- LOOKUP (1 cycle): hit = valid[idx] && tag match.
  - Read hit: dout_dram <= array data, hit_count++, go to RESP.
  - Read miss: miss_count++, mem_valid<=1, mem_rw<=0, mem_addr<=addr, go to MEM_REQ.
  - Write (hit or miss): mem_valid<=1, mem_rw<=1, mem_addr<=addr, mem_din<=din. On hit, overwrite data array this cycle. On miss, leave arrays untouched. Go to MEM_REQ.
- MEM_REQ: hold mem_* stable until mem_ready=1. Then drop mem_valid next edge. On a read, capture mem_dout into dout_dram and fill the line (data, tag, valid=1). Go to RESP.
- RESP: ready_dram=1 for exactly this cycle; next state IDLE. ready_dram is registered (high only in RESP).
- Latency from valid_dram seen in IDLE to ready_dram:
  - read hit: 2 cycles;
  - miss or write: 2 + controller latency + 1 cycles.
- Core side: valid_dram sampled only in IDLE. The core drops valid_dram at the edge ending RESP, so there is no double acceptance. A new request is accepted in the IDLE cycle right after RESP.
- mem_ready seen outside MEM_REQ: ignored.
- Write to a line whose tag mismatches (conflict): no eviction, line unchanged.
- Read miss on a conflicting index: replace the line unconditionally. No dirty state exists (write-through).
- Counters saturate at 32'hFFFF_FFFF; they do not wrap.
- rstn asserted mid-transaction: abandon immediately. mem_valid drops asynchronously, valid bits clear, no ready_dram is issued. The controller shares rstn.
- dout_dram holds its last value outside RESP.

Decomposition:
- Shared package holds:
  - state enum (IDLE, LOOKUP, MEM_REQ, RESP);
  - RW_READ=0 / RW_WRITE=1;
  - default ADDR_W/DATA_W constants, shared with core and controller top.
- Sub-module dram_cache_ram: single-port synchronous-read, synchronous-write RAM of width (tag+DATA_W) and depth 2**INDEX_W, inferring BRAM.
- Valid bits stay in dram_cache as a reset flop vector.

Test Plan:
- Read 0x0000123 cold; controller returns 0xDEADBEEF after 5 cycles → mem_valid once with mem_rw=0; ready_dram pulse with dout=0xDEADBEEF; miss_count=1. Re-read same address → no mem_valid, ready 2 cycles after accept, dout=0xDEADBEEF, hit_count=1.
- Write 0xCAFEF00D to 0x0000123 after fill → mem_valid, rw=1, mem_din=0xCAFEF00D. Subsequent read hits with 0xCAFEF00D and no controller access.
- Write to cold 0x0000456 → controller write issued; then read 0x0000456 → miss (no-allocate), miss_count increments.
- Fill index 0x123 with tag A (addr 0x0000123), then read 0x0000523 (same index, tag B) → miss and refill. Read 0x0000123 again → miss.
- Assert rstn low while in MEM_REQ → mem_valid=0 and ready_dram=0 immediately. After release, re-read a previously filled address → miss; counters read 0.
- Controller holds mem_ready low 100 cycles → mem_addr/mem_din/mem_rw stable and mem_valid high throughout, ready_dram never early. Back-to-back core reads accepted in IDLE right after each RESP.
